mem_wb_ctrl: RTL and testbench

- Merged MEM/WB stage: sits between the EX/MEM pipeline register and the register file write port (wEnable/wAddr/wData).
- Non-memory results pass through with 1-cycle registered latency.
- Loads and stores run a request/acknowledge transaction on the shared 16-bit RAM bus, under a bounded-wait FSM, and stall upstream stages until it completes.

---
 rtl/mem_wb_ctrl.sv | 146 ++++++++++++++
 tb/tb_mem_wb_ctrl.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_ctrl.sv
// mem_wb_ctrl: merged MEM/WB stage between the EX/MEM register and the regfile
// write port. ALU results pass through with one cycle of latency. Loads and
// stores run a req/ack transaction on the RAM bus under a bounded-wait FSM and
// stall upstream until the access completes or times out.
// Optional build macro UART_STATUS_EN: loads from 0xBF01 return the UART
// ready flags locally, and stores to 0xBF01 are dropped.
module mem_wb_ctrl #(
   parameter int DATA_W         = 16,
   parameter int REGA_W         = 4,
   parameter int TIMEOUT_CYCLES = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              valid_i,
   input  logic              wEnable_i,
   input  logic [REGA_W-1:0] wAddr_i,
   input  logic [DATA_W-1:0] wData_i,
   input  logic [1:0]        memOp_i,
   input  logic [DATA_W-1:0] memAddr_i,
   input  logic [DATA_W-1:0] memData_i,
   output logic              stall_o,
   output logic              ram_req_o,
   output logic              ram_we_o,
   output logic [DATA_W-1:0] ram_addr_o,
   output logic [DATA_W-1:0] ram_wdata_o,
   input  logic [DATA_W-1:0] ram_rdata_i,
   input  logic              ram_ack_i,
   input  logic              uart_rx_ready_i,
   input  logic              uart_tx_ready_i,
   output logic              wEnable_o,
   output logic [REGA_W-1:0] wAddr_o,
   output logic [DATA_W-1:0] wData_o,
   output logic              bus_err_o
);

   // Counter only needs to reach TIMEOUT_CYCLES-1 (the last WAIT cycle).
   localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);

   typedef enum logic {S_IDLE, S_WAIT} state_t;

   state_t              state;
   logic [CNT_W-1:0]    cnt;
   logic                cap_wen;
   logic [REGA_W-1:0]   cap_addr;

   logic                is_mem;
   logic                is_store;
   logic                uart_hit;
   logic [DATA_W-1:0]   uart_status;
   logic                bus_start;
   logic                timeout;

   assign is_mem   = valid_i & ((memOp_i == 2'b01) | (memOp_i == 2'b10));
   assign is_store = (memOp_i == 2'b10);

`ifdef UART_STATUS_EN
   localparam logic [DATA_W-1:0] UART_ADDR = DATA_W'(16'hBF01);
   assign uart_hit    = is_mem & (memAddr_i == UART_ADDR);
   assign uart_status = {{(DATA_W-2){1'b0}}, uart_rx_ready_i, uart_tx_ready_i};
`else
   logic unused_uart;
   assign uart_hit    = 1'b0;
   assign uart_status = '0;
   assign unused_uart = uart_rx_ready_i ^ uart_tx_ready_i;
`endif

   // A memory op that actually needs the bus (local UART accesses do not).
   assign bus_start = is_mem & ~uart_hit;
   // Last permitted WAIT cycle with no ack: abort on the next edge.
   assign timeout   = (state == S_WAIT) & ~ram_ack_i & (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

   // Upstream hold: accepting a bus op, or waiting with no ack and no timeout.
   always_comb begin
      stall_o = 1'b0;
      if (rst) begin
         if (state == S_IDLE) stall_o = bus_start;
         else                 stall_o = ~ram_ack_i & ~timeout;
      end
   end

   // Stage FSM: issues bus requests, tracks the wait budget, drives writeback.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= S_IDLE;
         cnt         <= '0;
         cap_wen     <= 1'b0;
         cap_addr    <= '0;
         ram_req_o   <= 1'b0;
         ram_we_o    <= 1'b0;
         ram_addr_o  <= '0;
         ram_wdata_o <= '0;
         wEnable_o   <= 1'b0;
         wAddr_o     <= '0;
         wData_o     <= '0;
         bus_err_o   <= 1'b0;
      end else begin
         bus_err_o <= 1'b0;
         case (state)
            S_IDLE: begin
               if (bus_start) begin
                  ram_req_o   <= 1'b1;
                  ram_we_o    <= is_store;
                  ram_addr_o  <= memAddr_i;
                  ram_wdata_o <= memData_i;
                  cnt         <= '0;
                  cap_wen     <= wEnable_i;
                  cap_addr    <= wAddr_i;
                  wEnable_o   <= 1'b0;
                  state       <= S_WAIT;
               end else begin
                  // ALU result, or a local UART access (store is dropped).
                  wEnable_o <= valid_i & wEnable_i & ~(uart_hit & is_store);
                  wAddr_o   <= wAddr_i;
                  wData_o   <= uart_hit ? uart_status : wData_i;
               end
            end
            S_WAIT: begin
               if (ram_ack_i) begin
                  ram_req_o <= 1'b0;
                  state     <= S_IDLE;
                  wEnable_o <= cap_wen & ~ram_we_o;
                  if (!ram_we_o) begin
                     wAddr_o <= cap_addr;
                     wData_o <= ram_rdata_i;
                  end
               end else if (timeout) begin
                  // Aborted load still retires, with zero data, so the
                  // destination register is never left stale.
                  ram_req_o <= 1'b0;
                  state     <= S_IDLE;
                  bus_err_o <= 1'b1;
                  wEnable_o <= cap_wen & ~ram_we_o;
                  if (!ram_we_o) begin
                     wAddr_o <= cap_addr;
                     wData_o <= '0;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_wb_ctrl.sv
// Self-checking bench for mem_wb_ctrl: directed scenarios plus a randomized
// instruction stream checked against a transaction-level model.
module tb_mem_wb_ctrl;
   localparam int DW = 16;
   localparam int AW = 4;
   localparam int TO = 15;
   localparam int NI = 300;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          valid_i, wEnable_i;
   logic [AW-1:0] wAddr_i;
   logic [DW-1:0] wData_i;
   logic [1:0]    memOp_i;
   logic [DW-1:0] memAddr_i, memData_i;
   logic          stall_o, ram_req_o, ram_we_o;
   logic [DW-1:0] ram_addr_o, ram_wdata_o;
   logic [DW-1:0] ram_rdata_i = '0;
   logic          ram_ack_i = 1'b0;
   logic          uart_rx_ready_i = 1'b0, uart_tx_ready_i = 1'b0;
   logic          wEnable_o;
   logic [AW-1:0] wAddr_o;
   logic [DW-1:0] wData_o;
   logic          bus_err_o;

   int checks = 0;
   int failures = 0;

   logic [AW+DW-1:0] exp_wb[$];
   int               err_seen = 0;
   int               exp_err = 0;

   typedef struct {
      logic          valid, wen;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic [1:0]    op;
      logic [DW-1:0] maddr, mdata, rdata;
      int            k;  // WAIT cycle carrying the ack; > TO means never
   } instr_t;

   mem_wb_ctrl #(.DATA_W(DW), .REGA_W(AW), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst(rst), .valid_i(valid_i), .wEnable_i(wEnable_i),
      .wAddr_i(wAddr_i), .wData_i(wData_i), .memOp_i(memOp_i),
      .memAddr_i(memAddr_i), .memData_i(memData_i), .stall_o(stall_o),
      .ram_req_o(ram_req_o), .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o),
      .ram_wdata_o(ram_wdata_o), .ram_rdata_i(ram_rdata_i), .ram_ack_i(ram_ack_i),
      .uart_rx_ready_i(uart_rx_ready_i), .uart_tx_ready_i(uart_tx_ready_i),
      .wEnable_o(wEnable_o), .wAddr_o(wAddr_o), .wData_o(wData_o),
      .bus_err_o(bus_err_o));

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_in;
      valid_i = 0; wEnable_i = 0; wAddr_i = '0; wData_i = '0;
      memOp_i = 2'b00; memAddr_i = '0; memData_i = '0;
   endtask

   task automatic set_in(input logic v, input logic we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [1:0] op,
                         input logic [DW-1:0] ma, input logic [DW-1:0] md);
      valid_i = v; wEnable_i = we; wAddr_i = a; wData_i = d;
      memOp_i = op; memAddr_i = ma; memData_i = md;
   endtask

   function automatic logic [AW+DW+2*DW+5:0] all_outs();
      return {wEnable_o, wAddr_o, wData_o, ram_req_o, ram_we_o, ram_addr_o,
              ram_wdata_o, bus_err_o, stall_o, 1'b0, 1'b0};
   endfunction

   task automatic test_reset;
      rst = 0;
      set_in(1, 1, 4'd5, 16'h1111, 2'b01, 16'h4000, 16'h2222);
      repeat (2) tick;
      checks++;
      if (all_outs() !== '0) begin
         failures++; $display("FAIL reset_outs got=%h exp=0", all_outs());
      end
      idle_in;
      rst = 1;
      tick;
      checks++;
      if (all_outs() !== '0) begin
         failures++; $display("FAIL reset_release got=%h exp=0", all_outs());
      end
   endtask

   task automatic test_alu;
      set_in(1, 1, 4'd3, 16'h1234, 2'b00, 16'h0, 16'h0);
      #1;
      checks++;
      if (stall_o !== 1'b0) begin failures++; $display("FAIL alu_stall got=%b exp=0", stall_o); end
      tick;
      idle_in;
      checks++;
      if ({wEnable_o, wAddr_o, wData_o} !== {1'b1, 4'd3, 16'h1234}) begin
         failures++; $display("FAIL alu_wb got=%b/%h/%h exp=1/3/1234", wEnable_o, wAddr_o, wData_o);
      end
      tick;
      checks++;
      if (wEnable_o !== 1'b0) begin failures++; $display("FAIL alu_wb_pulse got=%b exp=0", wEnable_o); end
   endtask

   task automatic test_load;
      set_in(1, 1, 4'd5, 16'h0, 2'b01, 16'h4000, 16'h0);
      ram_rdata_i = 16'hBEEF;
      #1;
      checks++;
      if (stall_o !== 1'b1) begin failures++; $display("FAIL load_accept_stall got=%b exp=1", stall_o); end
      for (int w = 1; w <= 3; w++) begin
         tick;
         ram_ack_i = (w == 3);
         #1;
         checks++;
         if ({ram_req_o, ram_we_o, ram_addr_o, stall_o} !== {1'b1, 1'b0, 16'h4000, (w != 3)}) begin
            failures++;
            $display("FAIL load_wait%0d req=%b we=%b addr=%h stall=%b exp req=1 we=0 addr=4000 stall=%b",
                     w, ram_req_o, ram_we_o, ram_addr_o, stall_o, (w != 3));
         end
      end
      tick;
      ram_ack_i = 0;
      idle_in;
      checks++;
      if ({ram_req_o, wEnable_o, wAddr_o, wData_o} !== {1'b0, 1'b1, 4'd5, 16'hBEEF}) begin
         failures++;
         $display("FAIL load_wb req=%b wb=%b/%h/%h exp req=0 wb=1/5/beef", ram_req_o, wEnable_o, wAddr_o, wData_o);
      end
      tick;
      checks++;
      if (wEnable_o !== 1'b0) begin failures++; $display("FAIL load_wb_pulse got=%b exp=0", wEnable_o); end
   endtask

   task automatic test_store;
      set_in(1, 1, 4'd9, 16'h0, 2'b10, 16'h8001, 16'h00AA);
      #1;
      checks++;
      if (stall_o !== 1'b1) begin failures++; $display("FAIL store_accept_stall got=%b exp=1", stall_o); end
      tick;
      ram_ack_i = 1;
      #1;
      checks++;
      if ({ram_req_o, ram_we_o, ram_addr_o, ram_wdata_o, stall_o} !== {1'b1, 1'b1, 16'h8001, 16'h00AA, 1'b0}) begin
         failures++;
         $display("FAIL store_bus req=%b we=%b addr=%h wdata=%h stall=%b exp 1/1/8001/00aa/0",
                  ram_req_o, ram_we_o, ram_addr_o, ram_wdata_o, stall_o);
      end
      tick;
      ram_ack_i = 0;
      idle_in;
      checks++;
      if ({ram_req_o, wEnable_o} !== 2'b00) begin
         failures++; $display("FAIL store_done req=%b wen=%b exp 0/0", ram_req_o, wEnable_o);
      end
   endtask

   task automatic test_timeout;
      int errs;
      errs = 0;
      set_in(1, 1, 4'd7, 16'hFFFF, 2'b01, 16'h1234, 16'h0);
      ram_rdata_i = 16'h5555;
      for (int w = 1; w <= TO; w++) begin
         tick;
         if (bus_err_o) errs++;
         #1;
         checks++;
         if ({ram_req_o, stall_o} !== {1'b1, (w < TO)}) begin
            failures++;
            $display("FAIL timeout_wait%0d req=%b stall=%b exp 1/%b", w, ram_req_o, stall_o, (w < TO));
         end
         if (w == TO) idle_in;
      end
      tick;
      checks++;
      if ({bus_err_o, ram_req_o, wEnable_o, wAddr_o, wData_o} !== {1'b1, 1'b0, 1'b1, 4'd7, 16'h0000}) begin
         failures++;
         $display("FAIL timeout_abort err=%b req=%b wb=%b/%h/%h exp 1/0/1/7/0000",
                  bus_err_o, ram_req_o, wEnable_o, wAddr_o, wData_o);
      end
      tick;
      if (bus_err_o) errs++;
      checks++;
      if ({errs, wEnable_o} !== {32'd0, 1'b0}) begin
         failures++; $display("FAIL timeout_pulse extra_errs=%0d wen=%b exp 0/0", errs, wEnable_o);
      end
   endtask

   task automatic test_reset_mid_wait;
      set_in(1, 1, 4'd6, 16'h0, 2'b01, 16'h2000, 16'h0);
      tick;
      tick;
      #2;
      rst = 0;
      #1;
      checks++;
      if (all_outs() !== '0) begin
         failures++; $display("FAIL rst_mid_wait got=%h exp=0", all_outs());
      end
      idle_in;
      tick;
      rst = 1;
      ram_ack_i = 1;
      ram_rdata_i = 16'h1111;
      tick;
      ram_ack_i = 0;
      checks++;
      if ({wEnable_o, ram_req_o, bus_err_o} !== 3'b000) begin
         failures++; $display("FAIL rst_late_ack wen=%b req=%b err=%b exp 0/0/0", wEnable_o, ram_req_o, bus_err_o);
      end
      tick;
      checks++;
      if (wEnable_o !== 1'b0) begin failures++; $display("FAIL rst_late_ack2 got=%b exp=0", wEnable_o); end
   endtask

   task automatic test_back_to_back;
      set_in(1, 1, 4'd1, 16'h0, 2'b01, 16'h0100, 16'h0);
      ram_rdata_i = 16'hC0DE;
      tick;
      ram_ack_i = 1;
      tick;
      ram_ack_i = 0;
      set_in(1, 0, 4'd2, 16'h0, 2'b10, 16'h0200, 16'h7777);
      #1;
      checks++;
      if ({wEnable_o, wAddr_o, wData_o, ram_req_o, stall_o} !== {1'b1, 4'd1, 16'hC0DE, 1'b0, 1'b1}) begin
         failures++;
         $display("FAIL b2b_load wb=%b/%h/%h req=%b stall=%b exp 1/1/c0de/0/1",
                  wEnable_o, wAddr_o, wData_o, ram_req_o, stall_o);
      end
      tick;
      checks++;
      if ({ram_req_o, ram_we_o, ram_addr_o, ram_wdata_o} !== {1'b1, 1'b1, 16'h0200, 16'h7777}) begin
         failures++;
         $display("FAIL b2b_store req=%b we=%b addr=%h wd=%h exp 1/1/0200/7777", ram_req_o, ram_we_o, ram_addr_o, ram_wdata_o);
      end
      ram_ack_i = 1;
      tick;
      ram_ack_i = 0;
      set_in(1, 1, 4'd4, 16'hABCD, 2'b00, 16'h0, 16'h0);
      #1;
      checks++;
      if ({stall_o, wEnable_o} !== 2'b00) begin
         failures++; $display("FAIL b2b_alu_issue stall=%b wen=%b exp 0/0", stall_o, wEnable_o);
      end
      tick;
      idle_in;
      checks++;
      if ({wEnable_o, wAddr_o, wData_o} !== {1'b1, 4'd4, 16'hABCD}) begin
         failures++; $display("FAIL b2b_alu_wb got=%b/%h/%h exp 1/4/abcd", wEnable_o, wAddr_o, wData_o);
      end
   endtask

`ifdef UART_STATUS_EN
   task automatic test_uart;
      uart_rx_ready_i = 1; uart_tx_ready_i = 0;
      set_in(1, 1, 4'd2, 16'h0, 2'b01, 16'hBF01, 16'h0);
      #1;
      checks++;
      if (stall_o !== 1'b0) begin failures++; $display("FAIL uart_stall got=%b exp=0", stall_o); end
      tick;
      idle_in;
      checks++;
      if ({ram_req_o, wEnable_o, wAddr_o, wData_o} !== {1'b0, 1'b1, 4'd2, 16'h0002}) begin
         failures++;
         $display("FAIL uart_load req=%b wb=%b/%h/%h exp 0/1/2/0002", ram_req_o, wEnable_o, wAddr_o, wData_o);
      end
      tick;
   endtask
`endif

   // Writeback/error monitor, called once per cycle just after the edge.
   task automatic mon;
      logic [AW+DW-1:0] e;
      if (wEnable_o) begin
         checks++;
         if (exp_wb.size() == 0) begin
            failures++; $display("FAIL rnd_wb_extra got=%h/%h exp=none", wAddr_o, wData_o);
         end else begin
            e = exp_wb.pop_front();
            if ({wAddr_o, wData_o} !== e) begin
               failures++; $display("FAIL rnd_wb got=%h/%h exp=%h/%h", wAddr_o, wData_o, e[AW+DW-1:DW], e[DW-1:0]);
            end
         end
      end
      if (bus_err_o) err_seen++;
   endtask

   task automatic test_random;
      instr_t cur;
      int     scnt, wcnt, exp_stall;
      logic   st, done;
      exp_wb.delete();
      err_seen = 0;
      exp_err = 0;
      for (int n = 0; n < NI; n++) begin
         cur.valid = ($urandom_range(0, 7) != 0);
         cur.wen   = $urandom_range(0, 1);
         cur.addr  = AW'($urandom);
         cur.wdata = DW'($urandom);
         cur.op    = 2'($urandom);
         cur.maddr = DW'($urandom);
         if (cur.maddr == 16'hBF01) cur.maddr = 16'hBF00;
         cur.mdata = DW'($urandom);
         cur.rdata = DW'($urandom);
         cur.k     = ($urandom_range(0, 3) == 0) ? $urandom_range(TO - 1, TO + 2) : $urandom_range(1, 4);
         // Transaction-level expectations for this instruction.
         exp_stall = 0;
         if (cur.valid && (cur.op == 2'b01 || cur.op == 2'b10)) begin
            exp_stall = (cur.k <= TO) ? cur.k : TO;
            if (cur.k > TO) exp_err++;
            if (cur.op == 2'b01 && cur.wen)
               exp_wb.push_back({cur.addr, (cur.k <= TO) ? cur.rdata : 16'h0000});
         end else if (cur.valid && cur.wen) begin
            exp_wb.push_back({cur.addr, cur.wdata});
         end
         set_in(cur.valid, cur.wen, cur.addr, cur.wdata, cur.op, cur.maddr, cur.mdata);
         scnt = 0; wcnt = 0; done = 0;
         for (int c = 0; c < 40 && !done; c++) begin
            if (ram_req_o) begin
               wcnt++;
               ram_ack_i = (wcnt == cur.k);
               ram_rdata_i = (wcnt == cur.k) ? cur.rdata : DW'($urandom);
               checks++;
               if ({ram_we_o, ram_addr_o, ram_wdata_o} !== {(cur.op == 2'b10), cur.maddr, cur.mdata}) begin
                  failures++;
                  $display("FAIL rnd_bus n=%0d got=%b/%h/%h exp=%b/%h/%h", n, ram_we_o, ram_addr_o,
                           ram_wdata_o, (cur.op == 2'b10), cur.maddr, cur.mdata);
               end
            end else begin
               ram_ack_i = ($urandom_range(0, 3) == 0);  // stray ack in IDLE
               ram_rdata_i = DW'($urandom);
            end
            #1;
            st = stall_o;
            if (st) scnt++;
            tick;
            ram_ack_i = 0;
            mon;
            if (!st) done = 1;
         end
         checks++;
         if (!done || scnt != exp_stall) begin
            failures++; $display("FAIL rnd_stall n=%0d got=%0d exp=%0d done=%b", n, scnt, exp_stall, done);
         end
      end
      idle_in;
      repeat (2) begin tick; mon; end
      checks++;
      if (exp_wb.size() != 0 || err_seen != exp_err) begin
         failures++;
         $display("FAIL rnd_totals pending_wb=%0d err_seen=%0d exp_err=%0d", exp_wb.size(), err_seen, exp_err);
      end
   endtask

   initial begin
      idle_in;
      #1;
      test_reset;
      test_alu;
      test_load;
      test_store;
      test_timeout;
      test_reset_mid_wait;
      test_back_to_back;
`ifdef UART_STATUS_EN
      test_uart;
`endif
      test_random;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout got=running exp=finished");
      $fatal(1, "bench time limit");
   end
endmodule
